// File: rtl/pll_seq_pkg.sv
// Shared types and widths for the PLL bring-up sequencer.
// The state encoding is visible on the LEDs, so the values are fixed.
package pll_seq_pkg;

    localparam int TIMER_W = 17;
    localparam int RETRY_W = 4;
    localparam int LOSS_W  = 4;

    typedef enum logic [2:0] {
        ST_RESET     = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_CHECK     = 3'd2,
        ST_RUN       = 3'd3,
        ST_FAIL      = 3'd4,
        ST_PWRDN     = 3'd5
    } state_t;

endpackage

// File: rtl/sync_2ff.sv
// W-bit two-flop synchronizer with synchronous active-low clear.
// Each bit is synchronized independently; no cross-bit coherence is implied.
module sync_2ff #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] meta;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/pll_bringup_seq.sv
// Board-clock sequencer that resets/powers the PLL, waits for lock, checks that
// every divided counter bit toggles, retries on failure and reports status.
module pll_bringup_seq
    import pll_seq_pkg::*;
#(
    parameter int unsigned RST_CYCLES   = 16,
    parameter int unsigned LOCK_TIMEOUT = 65536,
    parameter int unsigned ACT_WINDOW   = 65536,
    parameter int unsigned MAX_RETRIES  = 3,
    parameter int unsigned NCNT         = 6
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               restart,
    input  logic               pwrdwn_req,
    input  logic               locked_in,
    input  logic [NCNT-1:0]    cnt_in,
    output logic               pll_rst,
    output logic               pll_pwrdwn,
    output logic               ready,
    output logic               fail,
    output logic [2:0]         state_o,
    output logic [RETRY_W-1:0] retries,
    output logic [LOSS_W-1:0]  loss_cnt
);

    localparam logic [TIMER_W-1:0] RST_LAST  = TIMER_W'(RST_CYCLES - 1);
    localparam logic [TIMER_W-1:0] LOCK_LAST = TIMER_W'(LOCK_TIMEOUT - 1);
    localparam logic [TIMER_W-1:0] ACT_LAST  = TIMER_W'(ACT_WINDOW - 1);
    localparam logic [RETRY_W-1:0] RETRY_MAX = RETRY_W'(MAX_RETRIES);
    localparam logic [LOSS_W-1:0]  LOSS_SAT  = '1;

    state_t             state, state_next;
    logic [TIMER_W-1:0] timer, timer_next;
    logic [RETRY_W-1:0] retries_next;
    logic [LOSS_W-1:0]  loss_next;
    logic [NCNT-1:0]    seen, seen_next, cnt_s, cnt_d, tog;
    logic               locked_s, locked_d, lock_fall, attempt_fail;

    sync_2ff #(.W(1)) u_sync_lock (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (locked_in),
        .q     (locked_s)
    );

    sync_2ff #(.W(NCNT)) u_sync_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (cnt_in),
        .q     (cnt_s)
    );

    assign tog       = cnt_s ^ cnt_d;
    assign lock_fall = locked_d & ~locked_s;
    assign state_o   = state;

    always_comb begin
        state_next   = state;
        retries_next = retries;
        loss_next    = loss_cnt;
        attempt_fail = 1'b0;

        case (state)
            ST_RESET: begin
                if (timer == RST_LAST) state_next = ST_WAIT_LOCK;
            end
            ST_WAIT_LOCK: begin
                if (locked_s)                state_next   = ST_CHECK;
                else if (timer == LOCK_LAST) attempt_fail = 1'b1;
            end
            // Losing lock outranks completion, which outranks the window timeout.
            ST_CHECK: begin
                if (!locked_s) begin
                    attempt_fail = 1'b1;
                end else if (&seen) begin
                    state_next   = ST_RUN;
                    retries_next = '0;
                end else if (timer == ACT_LAST) begin
                    attempt_fail = 1'b1;
                end
            end
            ST_RUN: begin
                if (lock_fall) begin
                    attempt_fail = 1'b1;
                    if (loss_cnt != LOSS_SAT) loss_next = loss_cnt + 1'b1;
                end
            end
            ST_FAIL: begin
                if (restart) begin
                    state_next   = ST_RESET;
                    retries_next = '0;
                end
            end
            ST_PWRDN: begin
                if (!pwrdwn_req) begin
                    state_next   = ST_RESET;
                    retries_next = '0;
                end
            end
            default: state_next = ST_RESET;
        endcase

        if (attempt_fail) begin
            retries_next = retries + 1'b1;
            state_next   = (retries_next == RETRY_MAX) ? ST_FAIL : ST_RESET;
        end

        // Power-down pre-empts everything, including any fail bookkeeping this cycle.
        if (pwrdwn_req) begin
            state_next   = ST_PWRDN;
            retries_next = retries;
            loss_next    = loss_cnt;
        end

        timer_next = (state_next != state) ? '0 : ((&timer) ? timer : timer + 1'b1);
        seen_next  = (state == ST_CHECK) ? (seen | tog) : '0;
    end

    // Outputs are decoded from the next state so they switch on the same edge as state.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= ST_RESET;
            timer      <= '0;
            retries    <= '0;
            loss_cnt   <= '0;
            seen       <= '0;
            cnt_d      <= '0;
            locked_d   <= 1'b0;
            pll_rst    <= 1'b1;
            pll_pwrdwn <= 1'b0;
            ready      <= 1'b0;
            fail       <= 1'b0;
        end else begin
            state      <= state_next;
            timer      <= timer_next;
            retries    <= retries_next;
            loss_cnt   <= loss_next;
            seen       <= seen_next;
            cnt_d      <= cnt_s;
            locked_d   <= locked_s;
            pll_rst    <= state_next inside {ST_RESET, ST_FAIL, ST_PWRDN};
            pll_pwrdwn <= (state_next == ST_PWRDN);
            ready      <= (state_next == ST_RUN);
            fail       <= (state_next == ST_FAIL);
        end
    end

endmodule

// File: tb/tb_pll_bringup_seq.sv
// Scenario bench for pll_bringup_seq: expected state transitions are queued
// per scenario and popped as the DUT's state output changes.
module tb_pll_bringup_seq;

    localparam logic [2:0] S_RESET = 3'd0;
    localparam logic [2:0] S_WL    = 3'd1;
    localparam logic [2:0] S_CHECK = 3'd2;
    localparam logic [2:0] S_RUN   = 3'd3;
    localparam logic [2:0] S_FAIL  = 3'd4;
    localparam logic [2:0] S_PWRDN = 3'd5;

    typedef struct {
        logic [2:0] st;
        int         dur;
        int         ret;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       restart = 1'b0;
    logic       pwrdwn_req = 1'b0;
    logic       locked_in = 1'b0;
    logic [5:0] cnt_in;
    logic [5:0] stuck_mask = '0;
    logic       pll_rst, pll_pwrdwn, ready, fail;
    logic [2:0] state_o;
    logic [3:0] retries, loss_cnt;

    int   checks = 0;
    int   failures = 0;
    exp_t exp_q[$];

    pll_bringup_seq #(
        .RST_CYCLES   (4),
        .LOCK_TIMEOUT (16),
        .ACT_WINDOW   (32),
        .MAX_RETRIES  (2),
        .NCNT         (6)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .restart    (restart),
        .pwrdwn_req (pwrdwn_req),
        .locked_in  (locked_in),
        .cnt_in     (cnt_in),
        .pll_rst    (pll_rst),
        .pll_pwrdwn (pll_pwrdwn),
        .ready      (ready),
        .fail       (fail),
        .state_o    (state_o),
        .retries    (retries),
        .loss_cnt   (loss_cnt)
    );

    initial forever #5 clk = ~clk;

    // Divided PLL counters: unmasked bits toggle every 3 board cycles.
    initial begin
        int div;
        div    = 0;
        cnt_in = '0;
        forever begin
            @(negedge clk);
            div++;
            if (div == 3) begin
                div    = 0;
                cnt_in = cnt_in ^ ~stuck_mask;
            end
        end
    end

    task automatic wait_change(input int maxc, output logic [2:0] st, output int cyc, output bit ok);
        logic [2:0] cur;
        cur = state_o;
        cyc = 0;
        ok  = 1'b0;
        while (!ok && cyc < maxc) begin
            @(negedge clk);
            cyc++;
            if (state_o !== cur) ok = 1'b1;
        end
        st = state_o;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({pll_rst, pll_pwrdwn, ready, fail} !== 4'b1000) begin
            failures++;
            $display("[TB] FAIL reset_flags: got %b, want 1000", {pll_rst, pll_pwrdwn, ready, fail});
        end
        checks++;
        if ({state_o, retries, loss_cnt} !== 11'd0) begin
            failures++;
            $display("[TB] FAIL reset_regs: got state=%0d retries=%0d loss=%0d, want 0 0 0",
                     state_o, retries, loss_cnt);
        end
    endtask

    task automatic test_bringup();
        exp_t e;
        logic [2:0] st;
        int cyc;
        bit ok;
        int hi;
        locked_in  = 1'b0;
        stuck_mask = '0;
        rst_n      = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        fork
            begin
                repeat (10) @(negedge clk);
                locked_in = 1'b1;
            end
        join_none
        hi = 0;
        while (pll_rst === 1'b1 && hi < 50) begin
            hi++;
            @(negedge clk);
        end
        checks++;
        if (hi != 4) begin
            failures++;
            $display("[TB] FAIL bringup_rst_width: got %0d cycles, want 4", hi);
        end
        exp_q.push_back('{S_CHECK, 9, 0});
        exp_q.push_back('{S_RUN, -1, 0});
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            wait_change(200, st, cyc, ok);
            checks++;
            if (!ok || st !== e.st) begin
                failures++;
                $display("[TB] FAIL bringup_state: got %0d (changed=%0d), want %0d", st, ok, e.st);
            end
            if (e.dur >= 0) begin
                checks++;
                if (cyc != e.dur) begin
                    failures++;
                    $display("[TB] FAIL bringup_dur: got %0d, want %0d", cyc, e.dur);
                end
            end
            if (e.ret >= 0) begin
                checks++;
                if (retries !== e.ret[3:0]) begin
                    failures++;
                    $display("[TB] FAIL bringup_retries: got %0d, want %0d", retries, e.ret);
                end
            end
        end
        checks++;
        if ({ready, pll_rst, fail} !== 3'b100) begin
            failures++;
            $display("[TB] FAIL bringup_run_flags: got %b, want 100", {ready, pll_rst, fail});
        end
    endtask

    task automatic test_lock_timeout();
        exp_t e;
        logic [2:0] st;
        int cyc;
        bit ok;
        locked_in = 1'b0;
        do_reset();
        exp_q.push_back('{S_WL, 4, 0});
        exp_q.push_back('{S_RESET, 16, 1});
        exp_q.push_back('{S_WL, 4, 1});
        exp_q.push_back('{S_FAIL, 16, 2});
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            wait_change(200, st, cyc, ok);
            checks++;
            if (!ok || st !== e.st) begin
                failures++;
                $display("[TB] FAIL timeout_state: got %0d (changed=%0d), want %0d", st, ok, e.st);
            end
            if (e.dur >= 0) begin
                checks++;
                if (cyc != e.dur) begin
                    failures++;
                    $display("[TB] FAIL timeout_dur: got %0d, want %0d", cyc, e.dur);
                end
            end
            if (e.ret >= 0) begin
                checks++;
                if (retries !== e.ret[3:0]) begin
                    failures++;
                    $display("[TB] FAIL timeout_retries: got %0d, want %0d", retries, e.ret);
                end
            end
        end
        checks++;
        if ({fail, pll_rst, ready} !== 3'b110) begin
            failures++;
            $display("[TB] FAIL timeout_fail_flags: got %b, want 110", {fail, pll_rst, ready});
        end
        repeat (6) @(negedge clk);
        checks++;
        if (state_o !== S_FAIL) begin
            failures++;
            $display("[TB] FAIL fail_sticky: got %0d, want %0d", state_o, S_FAIL);
        end
        restart = 1'b1;
        @(negedge clk);
        restart = 1'b0;
        checks++;
        if (state_o !== S_RESET || retries !== 4'd0 || fail !== 1'b0) begin
            failures++;
            $display("[TB] FAIL restart: got state=%0d retries=%0d fail=%b, want 0 0 0",
                     state_o, retries, fail);
        end
    endtask

    task automatic test_check_timeout();
        exp_t e;
        logic [2:0] st;
        int cyc;
        bit ok;
        locked_in  = 1'b1;
        stuck_mask = 6'b100000;
        do_reset();
        exp_q.push_back('{S_WL, 4, 0});
        exp_q.push_back('{S_CHECK, 1, 0});
        exp_q.push_back('{S_RESET, 32, 1});
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            wait_change(200, st, cyc, ok);
            checks++;
            if (!ok || st !== e.st) begin
                failures++;
                $display("[TB] FAIL chk_to_state: got %0d (changed=%0d), want %0d", st, ok, e.st);
            end
            if (e.dur >= 0) begin
                checks++;
                if (cyc != e.dur) begin
                    failures++;
                    $display("[TB] FAIL chk_to_dur: got %0d, want %0d", cyc, e.dur);
                end
            end
            if (e.ret >= 0) begin
                checks++;
                if (retries !== e.ret[3:0]) begin
                    failures++;
                    $display("[TB] FAIL chk_to_retries: got %0d, want %0d", retries, e.ret);
                end
            end
        end
        checks++;
        if (pll_rst !== 1'b1) begin
            failures++;
            $display("[TB] FAIL chk_to_pll_rst: got %b, want 1", pll_rst);
        end
    endtask

    task automatic test_lock_loss();
        exp_t e;
        logic [2:0] st;
        int cyc;
        bit ok;
        locked_in  = 1'b1;
        stuck_mask = '0;
        do_reset();
        exp_q.push_back('{S_WL, 4, 0});
        exp_q.push_back('{S_CHECK, 1, 0});
        exp_q.push_back('{S_RUN, -1, 0});
        exp_q.push_back('{S_RESET, 3, 1});
        exp_q.push_back('{S_WL, 4, 1});
        exp_q.push_back('{S_CHECK, 4, 1});
        exp_q.push_back('{S_RUN, -1, 0});
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            if (e.st == S_RESET) begin
                locked_in = 1'b0;
                fork
                    begin
                        repeat (8) @(negedge clk);
                        locked_in = 1'b1;
                    end
                join_none
            end
            wait_change(200, st, cyc, ok);
            checks++;
            if (!ok || st !== e.st) begin
                failures++;
                $display("[TB] FAIL loss_state: got %0d (changed=%0d), want %0d", st, ok, e.st);
            end
            if (e.dur >= 0) begin
                checks++;
                if (cyc != e.dur) begin
                    failures++;
                    $display("[TB] FAIL loss_dur: got %0d, want %0d", cyc, e.dur);
                end
            end
            if (e.ret >= 0) begin
                checks++;
                if (retries !== e.ret[3:0]) begin
                    failures++;
                    $display("[TB] FAIL loss_retries: got %0d, want %0d", retries, e.ret);
                end
            end
        end
        checks++;
        if (loss_cnt !== 4'd1 || ready !== 1'b1) begin
            failures++;
            $display("[TB] FAIL loss_cnt: got loss=%0d ready=%b, want 1 1", loss_cnt, ready);
        end
    endtask

    task automatic test_reset_mid_check();
        exp_t e;
        logic [2:0] st;
        int cyc;
        bit ok;
        stuck_mask = 6'b100000;
        locked_in  = 1'b0;
        fork
            begin
                repeat (8) @(negedge clk);
                locked_in = 1'b1;
            end
        join_none
        exp_q.push_back('{S_RESET, 3, 1});
        exp_q.push_back('{S_WL, 4, 1});
        exp_q.push_back('{S_CHECK, 4, 1});
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            wait_change(200, st, cyc, ok);
            checks++;
            if (!ok || st !== e.st) begin
                failures++;
                $display("[TB] FAIL midchk_state: got %0d (changed=%0d), want %0d", st, ok, e.st);
            end
            if (e.dur >= 0) begin
                checks++;
                if (cyc != e.dur) begin
                    failures++;
                    $display("[TB] FAIL midchk_dur: got %0d, want %0d", cyc, e.dur);
                end
            end
            if (e.ret >= 0) begin
                checks++;
                if (retries !== e.ret[3:0]) begin
                    failures++;
                    $display("[TB] FAIL midchk_retries: got %0d, want %0d", retries, e.ret);
                end
            end
        end
        repeat (5) @(negedge clk);
        checks++;
        if (state_o !== S_CHECK || loss_cnt !== 4'd2) begin
            failures++;
            $display("[TB] FAIL midchk_pre: got state=%0d loss=%0d, want 2 2", state_o, loss_cnt);
        end
        rst_n = 1'b0;
        @(negedge clk);
        checks++;
        if ({pll_rst, pll_pwrdwn, ready, fail} !== 4'b1000 ||
            {state_o, retries, loss_cnt} !== 11'd0) begin
            failures++;
            $display("[TB] FAIL midchk_reset: got flags=%b state=%0d retries=%0d loss=%0d, want 1000 0 0 0",
                     {pll_rst, pll_pwrdwn, ready, fail}, state_o, retries, loss_cnt);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_pwrdn();
        exp_t e;
        logic [2:0] st;
        int cyc;
        bit ok;
        locked_in  = 1'b0;
        stuck_mask = '0;
        do_reset();
        exp_q.push_back('{S_WL, 4, 0});
        exp_q.push_back('{S_RESET, 16, 1});
        exp_q.push_back('{S_WL, 4, 1});
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            wait_change(200, st, cyc, ok);
            checks++;
            if (!ok || st !== e.st) begin
                failures++;
                $display("[TB] FAIL pwrdn_state: got %0d (changed=%0d), want %0d", st, ok, e.st);
            end
            if (e.dur >= 0) begin
                checks++;
                if (cyc != e.dur) begin
                    failures++;
                    $display("[TB] FAIL pwrdn_dur: got %0d, want %0d", cyc, e.dur);
                end
            end
            if (e.ret >= 0) begin
                checks++;
                if (retries !== e.ret[3:0]) begin
                    failures++;
                    $display("[TB] FAIL pwrdn_retries: got %0d, want %0d", retries, e.ret);
                end
            end
        end
        repeat (3) @(negedge clk);
        pwrdwn_req = 1'b1;
        restart    = 1'b1;
        @(negedge clk);
        restart = 1'b0;
        checks++;
        if (state_o !== S_PWRDN || {pll_pwrdwn, pll_rst} !== 2'b11 || retries !== 4'd1) begin
            failures++;
            $display("[TB] FAIL pwrdn_enter: got state=%0d pwrdwn=%b rst=%b retries=%0d, want 5 1 1 1",
                     state_o, pll_pwrdwn, pll_rst, retries);
        end
        repeat (4) @(negedge clk);
        checks++;
        if (state_o !== S_PWRDN) begin
            failures++;
            $display("[TB] FAIL pwrdn_hold: got %0d, want %0d", state_o, S_PWRDN);
        end
        pwrdwn_req = 1'b0;
        @(negedge clk);
        checks++;
        if (state_o !== S_RESET || retries !== 4'd0 || pll_pwrdwn !== 1'b0) begin
            failures++;
            $display("[TB] FAIL pwrdn_release: got state=%0d retries=%0d pwrdwn=%b, want 0 0 0",
                     state_o, retries, pll_pwrdwn);
        end
    endtask

    initial begin
        test_reset();
        test_bringup();
        test_lock_timeout();
        test_check_timeout();
        test_lock_loss();
        test_reset_mid_check();
        test_pwrdn();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
